// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: owns the program store, holds the PC and hands the CPU
// one instruction per LoadIRSig rising edge until the halt word is fetched.
module instr_fetch_seq #(
  parameter int              DEPTH     = 16,
  parameter int              AW        = 4,
  parameter int              IW        = 8,
  parameter logic [IW-1:0]   HALT_WORD = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_prog_we,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [IW-1:0] i_prog_data,
  input  logic          i_start,
  input  logic          i_load_ir,
  input  logic          i_jump_en,
  input  logic [AW-1:0] i_jump_addr,
  output logic [IW-1:0] o_instruction,
  output logic          o_instr_valid,
  output logic [AW-1:0] o_pc,
  output logic          o_busy,
  output logic          o_halted,
  output logic          o_prog_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_instr;
  logic [AW-1:0] r_pc;
  logic          r_valid;
  logic          r_err;
  logic          r_load_ir_q;

  logic          w_run;
  logic          w_req;
  logic          w_fetch;
  logic [AW-1:0] w_a;
  logic [IW-1:0] w_word;
  logic          w_is_halt;
  logic          w_start_ok;

  assign w_run      = (r_state == S_RUN);
  assign w_req      = i_load_ir & ~r_load_ir_q;
  assign w_fetch    = w_run & w_req;
  assign w_a        = i_jump_en ? i_jump_addr : r_pc;
  assign w_word     = r_mem[w_a];
  assign w_is_halt  = (w_word == HALT_WORD);
  assign w_start_ok = i_start & ~w_run;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_RUN;
      S_RUN:  if (w_fetch && w_is_halt) w_state_nxt = S_HALT;
      S_HALT: if (i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Program writes are only accepted while not executing.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_err <= 1'b0;
    end else if (i_prog_we) begin
      if (w_run) r_err <= 1'b1;
      else       r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc        <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_load_ir_q <= 1'b0;
    end else begin
      r_load_ir_q <= i_load_ir;
      r_valid     <= w_fetch;
      if (w_start_ok) begin
        r_pc <= '0;
      end else if (w_fetch) begin
        r_instr <= w_word;
        r_pc    <= w_is_halt ? w_a : w_a + 1'b1;
      end else if (w_run && i_jump_en) begin
        r_pc <= i_jump_addr;
      end
    end
  end

  assign o_instruction = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc          = r_pc;
  assign o_busy        = w_run;
  assign o_halted      = (r_state == S_HALT);
  assign o_prog_err    = r_err;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: load, fetch, halt, hold, jump,
// wrap, write-protect and reset scenarios with hand-computed results.
module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       start = 1'b0;
  logic       load_ir = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] jump_addr = '0;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       busy;
  logic       halted;
  logic       prog_err;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_seq dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_prog_we     (prog_we),
    .i_prog_addr   (prog_addr),
    .i_prog_data   (prog_data),
    .i_start       (start),
    .i_load_ir     (load_ir),
    .i_jump_en     (jump_en),
    .i_jump_addr   (jump_addr),
    .o_instruction (instruction),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_busy        (busy),
    .o_halted      (halted),
    .o_prog_err    (prog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] ei,
                       input logic [3:0] ep);
    load_ir = 1'b1;
    tick();
    check({tag, ".valid"}, instr_valid, 1);
    check({tag, ".instr"}, instruction, ei);
    check({tag, ".pc"}, pc, ep);
    load_ir = 1'b0;
    tick();
    check({tag, ".vdrop"}, instr_valid, 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] prog [4];
    prog[0] = 8'hD1; prog[1] = 8'h51; prog[2] = 8'hD2; prog[3] = 8'h11;

    // 1: reset, load, four fetches
    #2 reset = 1'b1;
    #1;
    check("rst.instr", instruction, 0);
    check("rst.valid", instr_valid, 0);
    check("rst.pc", pc, 0);
    check("rst.busy", busy, 0);
    check("rst.halted", halted, 0);
    check("rst.err", prog_err, 0);
    #4 reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) wr(4'(i), prog[i]);
    do_start();
    check("t1.busy", busy, 1);
    check("t1.pc0", pc, 0);
    for (int i = 0; i < 4; i++) fetch("t1", prog[i], 4'(i + 1));

    // 2: halt word at mem[4], then ignored request
    fetch("t2", 8'h00, 4'd4);
    check("t2.halted", halted, 1);
    check("t2.busy", busy, 0);
    load_ir = 1'b1;
    tick();
    check("t2.novalid", instr_valid, 0);
    check("t2.hold", instruction, 8'h00);
    load_ir = 1'b0;
    tick();

    // 3: restart from HALT, held level gives one fetch
    do_start();
    check("t3.busy", busy, 1);
    check("t3.halted", halted, 0);
    load_ir = 1'b1;
    tick();
    check("t3.valid", instr_valid, 1);
    check("t3.instr", instruction, 8'hD1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3.held", instr_valid, 0);
    end
    check("t3.pc", pc, 1);
    load_ir = 1'b0;
    tick();

    // 4: same-cycle jump, then jump without request
    load_ir = 1'b1; jump_en = 1'b1; jump_addr = 4'd2;
    tick();
    check("t4.valid", instr_valid, 1);
    check("t4.instr", instruction, 8'hD2);
    check("t4.pc", pc, 3);
    load_ir = 1'b0; jump_en = 1'b0;
    tick();
    jump_en = 1'b1; jump_addr = 4'd0;
    tick();
    jump_en = 1'b0;
    check("t4.jpc", pc, 0);
    check("t4.jvalid", instr_valid, 0);
    check("t4.jinstr", instruction, 8'hD2);

    // 5: full memory, PC wrap
    do_reset();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hA0 + 8'(i));
    do_start();
    for (int i = 0; i < 16; i++) fetch("t5", 8'hA0 + 8'(i), 4'((i + 1) % 16));
    fetch("t5.wrap", 8'hA0, 4'd1);
    check("t5.busy", busy, 1);

    // 6: write in RUN rejected, reset mid-fetch, write+start together
    wr(4'd0, 8'h55);
    check("t6.err", prog_err, 1);
    load_ir = 1'b1; jump_en = 1'b1; jump_addr = 4'd0;
    tick();
    check("t6.memkeep", instruction, 8'hA0);
    load_ir = 1'b0; jump_en = 1'b0;
    tick();
    load_ir = 1'b1;
    reset = 1'b1;
    #1;
    check("t6.r.instr", instruction, 0);
    check("t6.r.pc", pc, 0);
    check("t6.r.busy", busy, 0);
    check("t6.r.err", prog_err, 0);
    tick();
    check("t6.r.valid", instr_valid, 0);
    load_ir = 1'b0;
    #2 reset = 1'b0;
    tick();
    do_start();
    fetch("t6.clr", 8'h00, 4'd0);
    check("t6.clrhalt", halted, 1);
    do_reset();
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h3C; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    check("t6.ws.busy", busy, 1);
    fetch("t6.ws", 8'h3C, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
